// File: rtl/crc_gen_16bit_tx.sv
// crc_gen_16bit_tx: USB Tx CRC16 generator; serializes payload bytes LSB-first, then appends the inverted CRC.
module crc_gen_16bit_tx #(
    parameter logic [15:0] CRC_INIT = 16'hFFFF,
    parameter logic [15:0] CRC_POLY = 16'hA001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_enable,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    input  logic        crc_only,
    output logic        byte_ready,
    output logic        serial_out,
    output logic        tx_active,
    output logic [15:0] crc_value,
    output logic        done,
    output logic        underrun
);
    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
    state_t state, state_d;
    logic [7:0]  sr;
    logic        last_q;
    logic [15:0] crc, crc_next;
    logic [3:0]  bit_cnt;
    logic        xfer, bnd;
    assign xfer = byte_valid && byte_ready;
    assign bnd = shift_enable && bit_cnt == 4'd7;
    assign crc_next = (crc >> 1) ^ ((crc[0] ^ serial_out) ? CRC_POLY : 16'h0000);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE: state_d = xfer ? DATA : crc_only ? CRC : IDLE;
            DATA: if (bnd && !xfer) state_d = last_q ? CRC : IDLE;
            CRC: if (shift_enable && bit_cnt == 4'd15) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // byte_ready at a DATA boundary is combinational so the next byte lands without a gap bit
    always_comb begin
        byte_ready = !rst && (state == IDLE || (state == DATA && bnd && !last_q));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= 8'h00;
            last_q     <= 1'b0;
            crc        <= CRC_INIT;
            bit_cnt    <= 4'd0;
            serial_out <= 1'b1;
            tx_active  <= 1'b0;
            crc_value  <= 16'h0000;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sr         <= byte_in;
                        last_q     <= byte_last;
                        crc        <= CRC_INIT;
                        bit_cnt    <= 4'd0;
                        serial_out <= byte_in[0];
                        tx_active  <= 1'b1;
                    end else if (crc_only) begin
                        crc_value  <= ~CRC_INIT;
                        serial_out <= ~CRC_INIT[0];
                        bit_cnt    <= 4'd0;
                        tx_active  <= 1'b1;
                    end
                end
                DATA: begin
                    if (shift_enable) begin
                        crc <= crc_next;
                        if (bit_cnt != 4'd7) begin
                            bit_cnt    <= bit_cnt + 4'd1;
                            serial_out <= sr[bit_cnt[2:0] + 3'd1];
                        end else if (xfer) begin
                            sr         <= byte_in;
                            last_q     <= byte_last;
                            bit_cnt    <= 4'd0;
                            serial_out <= byte_in[0];
                        end else if (last_q) begin
                            crc_value  <= ~crc_next;
                            serial_out <= ~crc_next[0];
                            bit_cnt    <= 4'd0;
                        end else begin
                            underrun   <= 1'b1;
                            serial_out <= 1'b1;
                            tx_active  <= 1'b0;
                            bit_cnt    <= 4'd0;
                        end
                    end
                end
                CRC: begin
                    if (shift_enable) begin
                        if (bit_cnt == 4'd15) begin
                            done       <= 1'b1;
                            serial_out <= 1'b1;
                            tx_active  <= 1'b0;
                            bit_cnt    <= 4'd0;
                        end else begin
                            bit_cnt    <= bit_cnt + 4'd1;
                            serial_out <= crc_value[bit_cnt + 4'd1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_gen_16bit_tx.sv
// tb_crc_gen_16bit_tx: randomized and directed packets checked against a bit-queue reference model.
module tb_crc_gen_16bit_tx;
    logic        clk = 1'b0, rst = 1'b1, shift_enable = 1'b0, byte_valid = 1'b0;
    logic        byte_last = 1'b0, crc_only = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready, serial_out, tx_active, done, underrun;
    logic [15:0] crc_value;
    crc_gen_16bit_tx dut (
        .clk(clk), .rst(rst), .shift_enable(shift_enable), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .crc_only(crc_only),
        .byte_ready(byte_ready), .serial_out(serial_out), .tx_active(tx_active),
        .crc_value(crc_value), .done(done), .underrun(underrun)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    logic [7:0]  pkt [16];
    bit          exp_q[$], cap_q[$];
    logic [15:0] exp_crc;
    int          done_cnt, und_cnt, unstable, rdy_bad;
    bit          got_end;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] step(input logic [15:0] c, input bit b);
        return (c >> 1) ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
    endfunction
    task automatic run_pkt(input int n, input int per, input bit last, input int abort);
        logic [15:0] m = 16'hFFFF;
        int idx = 0, c = 0;
        bit prev_se = 1'b1, prev_so = 1'b1, prev_act = 1'b0;
        exp_q = {};
        cap_q = {};
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) exp_q.push_back(pkt[i][j]);
        foreach (exp_q[i]) m = step(m, exp_q[i]);
        exp_crc = ~m;
        if (last || n == 0)
            for (int j = 0; j < 16; j++) exp_q.push_back(exp_crc[j]);
        done_cnt = 0; und_cnt = 0; unstable = 0; rdy_bad = 0; got_end = 0;
        while (!got_end && c < 4000) begin
            @(negedge clk);
            rst = abort >= 0 && cap_q.size() >= abort;
            shift_enable = (c % per) == 0;
            byte_valid = idx < n;
            byte_in = idx < n ? pkt[idx] : 8'($urandom);
            byte_last = last && idx == n - 1;
            crc_only = n == 0 && c == 0;
            #1;
            if (done) done_cnt++;
            if (underrun) und_cnt++;
            if (tx_active && prev_act && !prev_se && serial_out !== prev_so) unstable++;
            if (tx_active && cap_q.size() >= 8 * n && byte_ready) rdy_bad++;
            if (tx_active && shift_enable) cap_q.push_back(serial_out);
            if (byte_valid && byte_ready) idx++;
            prev_se = shift_enable;
            prev_so = serial_out;
            prev_act = tx_active;
            if (done || underrun || rst) got_end = 1;
            c++;
        end
        shift_enable = 1'b0;
        byte_valid = 1'b0;
        crc_only = 1'b0;
        if (!got_end) check("timeout", 32'(got_end), 32'd1);
    endtask
    task automatic check_pkt(input string tag, input bit full);
        int bad = 0;
        logic [15:0] r = 16'hFFFF;
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        foreach (cap_q[i]) if (i < exp_q.size() && cap_q[i] != exp_q[i]) bad++;
        check({tag, "_bits"}, bad, 0);
        check({tag, "_done"}, done_cnt, full ? 1 : 0);
        check({tag, "_underrun"}, und_cnt, full ? 0 : 1);
        check({tag, "_stable"}, unstable, 0);
        check({tag, "_ready_in_crc"}, rdy_bad, 0);
        if (full) begin
            check({tag, "_crc"}, crc_value, exp_crc);
            foreach (cap_q[i]) r = step(r, cap_q[i]);
            check({tag, "_residual"}, r, 16'hB001);
        end
    endtask
    task automatic load_ascii();
        for (int i = 0; i < 9; i++) pkt[i] = 8'h31 + 8'(i);
    endtask
    initial begin
        @(negedge clk);
        rst = 1'b1; byte_valid = 1'b1; shift_enable = 1'b1;
        #1 check("rst_ready", byte_ready, 1'b0);
        @(negedge clk);
        #1;
        check("rst_serial", serial_out, 1'b1);
        check("rst_active", tx_active, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_crc", crc_value, 16'h0000);
        rst = 1'b0; byte_valid = 1'b0; shift_enable = 1'b0;
        repeat (2) @(negedge clk);
        load_ascii();
        run_pkt(9, 1, 1'b1, -1);
        check_pkt("ascii", 1'b1);
        check("ascii_known", crc_value, 16'hB4C8);
        run_pkt(9, 4, 1'b1, -1);
        check_pkt("ascii_slow", 1'b1);
        check("ascii_slow_known", crc_value, 16'hB4C8);
        run_pkt(0, 1, 1'b0, -1);
        check_pkt("crc_only", 1'b1);
        check("crc_only_known", crc_value, 16'h0000);
        run_pkt(2, 1, 1'b0, -1);
        check_pkt("underrun", 1'b0);
        @(negedge clk);
        #1 check("underrun_idle", tx_active, 1'b0);
        run_pkt(9, 2, 1'b1, 77);
        check("abort_done", done_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_serial", serial_out, 1'b1);
        check("abort_active", tx_active, 1'b0);
        check("abort_crc", crc_value, 16'h0000);
        check("abort_done_pulse", done, 1'b0);
        check("abort_underrun", underrun, 1'b0);
        run_pkt(9, 1, 1'b1, -1);
        check_pkt("after_abort", 1'b1);
        check("after_abort_known", crc_value, 16'hB4C8);
        for (int t = 0; t < 8; t++) begin
            int n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
            run_pkt(n, $urandom_range(3, 1), 1'b1, -1);
            check_pkt($sformatf("rand%0d", t), 1'b1);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
